// File: rtl/module_frame_rx.sv
// -----------------------------------------------------------------------------
// module_frame_rx
// Receive decoder for the inverter command link on a power-module board.
// Reassembles the two-byte frame {sin_index[11:4]} {sin_index[3:0], uart_id}
// delivered by uart_rx, holds an accepted frame as pending, and commits the
// pending index to active_index on the rising edge of the broadcast shoot line
// so that every module switches on the same event.
//
// Optional feature macro: FRAME_ID_FILTER_EN
//   defined   : only frames addressed to MODULE_ID or to 4'hF are accepted
//   undefined : every parity-clean completed frame is accepted
//
// Parameters:
//   MODULE_ID       id this board answers to (filter build only)
//   TIMEOUT_CYCLES  max clk cycles between byte-1 and byte-2 strobes (2..65535)
//
// Ports:
//   clk           24 MHz clock shared with uart_rx
//   reset         asynchronous active-low reset
//   rx_byte       received byte, valid while rx_done=1
//   rx_done       one-cycle byte strobe
//   parity_error  qualifies the current rx_done
//   shoot         raw broadcast shoot pin, asynchronous to clk
//   sin_index     last fully received index
//   uart_id       last fully received id
//   frame_valid   one-cycle pulse when a frame completes
//   frame_error   one-cycle pulse on parity error or inter-byte timeout
//   active_index  committed index driving the gate logic
//   apply         one-cycle pulse when active_index updates
//   missed_shoot  one-cycle pulse on a shoot edge with nothing pending
// -----------------------------------------------------------------------------
module module_frame_rx #(
  parameter logic [3:0]  MODULE_ID      = 4'd1,
  parameter int unsigned TIMEOUT_CYCLES = 2400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_done,
  input  logic        parity_error,
  input  logic        shoot,
  output logic [11:0] sin_index,
  output logic [3:0]  uart_id,
  output logic        frame_valid,
  output logic        frame_error,
  output logic [11:0] active_index,
  output logic        apply,
  output logic        missed_shoot
);

`ifdef FRAME_ID_FILTER_EN
  localparam logic FILTER_EN = 1'b1;
`else
  localparam logic FILTER_EN = 1'b0;
`endif

  // Counter value at which the wait for byte 2 expires.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [7:0]  hi_byte, hi_byte_next;
  logic [15:0] tcount, tcount_next;
  logic [11:0] pending_index, pending_index_next;
  logic        pending, pending_next;
  logic [11:0] sin_index_next;
  logic [3:0]  uart_id_next;
  logic        frame_valid_next, frame_error_next;
  logic [11:0] active_index_next;
  logic        apply_next, missed_shoot_next;
  logic        frame_done, frame_accept;
  logic        shoot_s1, shoot_s2, shoot_s3;
  logic        shoot_edge;

  // Rising edge of the synchronized shoot line; a held level yields one edge.
  assign shoot_edge = shoot_s2 & ~shoot_s3;

  // Frame FSM: next state, byte assembly and inter-byte timeout.
  always_comb begin
    state_next       = state;
    hi_byte_next     = hi_byte;
    tcount_next      = tcount;
    sin_index_next   = sin_index;
    uart_id_next     = uart_id;
    frame_valid_next = 1'b0;
    frame_error_next = 1'b0;
    frame_done       = 1'b0;
    case (state)
      WAIT_HI: begin
        if (rx_done) begin
          if (!parity_error) begin
            hi_byte_next = rx_byte;
            tcount_next  = 16'd0;
            state_next   = WAIT_LO;
          end else begin
            frame_error_next = 1'b1;
          end
        end else begin
          state_next = WAIT_HI;
        end
      end
      WAIT_LO: begin
        // A strobe on the timeout cycle still completes the frame.
        if (rx_done) begin
          state_next = WAIT_HI;
          if (!parity_error) begin
            sin_index_next   = {hi_byte, rx_byte[7:4]};
            uart_id_next     = rx_byte[3:0];
            frame_valid_next = 1'b1;
            frame_done       = 1'b1;
          end else begin
            frame_error_next = 1'b1;
          end
        end else if (tcount == TIMEOUT_LAST) begin
          frame_error_next = 1'b1;
          state_next       = WAIT_HI;
        end else if (tcount != 16'hFFFF) begin
          tcount_next = tcount + 16'd1;
        end else begin
          tcount_next = tcount;
        end
      end
      default: begin
        state_next = WAIT_HI;
      end
    endcase
  end

  // Acceptance rule; the id filter only exists in the filter build.
  always_comb begin
    if (frame_done && (!FILTER_EN || (rx_byte[3:0] == MODULE_ID) || (rx_byte[3:0] == 4'hF))) begin
      frame_accept = 1'b1;
    end else begin
      frame_accept = 1'b0;
    end
  end

  // Pending/commit path: the commit reads the old pending value before a
  // simultaneously accepted frame replaces it.
  always_comb begin
    active_index_next  = active_index;
    pending_next       = pending;
    pending_index_next = pending_index;
    apply_next         = 1'b0;
    missed_shoot_next  = 1'b0;
    if (shoot_edge) begin
      if (pending) begin
        active_index_next = pending_index;
        apply_next        = 1'b1;
        pending_next      = 1'b0;
      end else begin
        missed_shoot_next = 1'b1;
      end
    end else begin
      apply_next = 1'b0;
    end
    if (frame_accept) begin
      pending_index_next = sin_index_next;
      pending_next       = 1'b1;
    end else begin
      pending_index_next = pending_index;
    end
  end

  // State, data and pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= WAIT_HI;
      hi_byte       <= 8'd0;
      tcount        <= 16'd0;
      pending_index <= 12'd0;
      pending       <= 1'b0;
      sin_index     <= 12'd0;
      uart_id       <= 4'd0;
      frame_valid   <= 1'b0;
      frame_error   <= 1'b0;
      active_index  <= 12'd0;
      apply         <= 1'b0;
      missed_shoot  <= 1'b0;
    end else begin
      state         <= state_next;
      hi_byte       <= hi_byte_next;
      tcount        <= tcount_next;
      pending_index <= pending_index_next;
      pending       <= pending_next;
      sin_index     <= sin_index_next;
      uart_id       <= uart_id_next;
      frame_valid   <= frame_valid_next;
      frame_error   <= frame_error_next;
      active_index  <= active_index_next;
      apply         <= apply_next;
      missed_shoot  <= missed_shoot_next;
    end
  end

  // Two-flop synchronizer for the asynchronous shoot pin plus edge-detect flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shoot_s1 <= 1'b0;
      shoot_s2 <= 1'b0;
      shoot_s3 <= 1'b0;
    end else begin
      shoot_s1 <= shoot;
      shoot_s2 <= shoot_s1;
      shoot_s3 <= shoot_s2;
    end
  end

endmodule

// File: tb/tb_module_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_module_frame_rx
// Scoreboard bench for module_frame_rx. Stimulus runs edge by edge; after each
// sampling edge a transaction-level model of the link decides which events
// (frame done/error, apply/missed) must appear and at which edge, and pushes
// them into queues. A monitor on the falling edge pops and compares whenever
// the DUT pulses, and flags pulses that never arrive.
// -----------------------------------------------------------------------------
module tb_module_frame_rx;

  localparam int unsigned T   = 16;
  localparam logic [3:0]  MID = 4'd1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_done = 1'b0;
  logic        parity_error = 1'b0;
  logic        shoot = 1'b0;
  logic [11:0] sin_index;
  logic [3:0]  uart_id;
  logic        frame_valid;
  logic        frame_error;
  logic [11:0] active_index;
  logic        apply;
  logic        missed_shoot;

  module_frame_rx #(.MODULE_ID(MID), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_done(rx_done),
    .parity_error(parity_error), .shoot(shoot), .sin_index(sin_index),
    .uart_id(uart_id), .frame_valid(frame_valid), .frame_error(frame_error),
    .active_index(active_index), .apply(apply), .missed_shoot(missed_shoot)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // kind: 2'b10 = frame_valid / apply, 2'b01 = frame_error / missed_shoot
  typedef struct {
    int unsigned at;
    logic [1:0]  kind;
    logic [11:0] idx;
    logic [3:0]  id;
  } ev_t;

  ev_t fq[$];
  ev_t sq[$];

  // ---------------- reference model (transaction level) ----------------
  bit          m_in_frame = 1'b0;
  logic [7:0]  m_hi = 8'h00;
  int unsigned m_hi_edge = 0;
  bit          m_pending = 1'b0;
  logic [11:0] m_pidx = 12'h000;
  logic [11:0] m_active = 12'h000;
  bit          m_shoot_prev = 1'b0;
  int unsigned m_commit[$];
  logic [11:0] m_last_sin = 12'h000;
  logic [3:0]  m_last_id = 4'h0;

  function automatic bit accepts(input logic [3:0] id);
`ifdef FRAME_ID_FILTER_EN
    return (id == MID) || (id == 4'hF);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_step(input int unsigned n, input logic d, input logic [7:0] b,
                            input logic p, input logic s);
    ev_t e;
    // byte 2 missing for T edges after byte 1
    if (m_in_frame && !d && (n == m_hi_edge + T)) begin
      e = '{n, 2'b01, 12'h000, 4'h0};
      fq.push_back(e);
      m_in_frame = 1'b0;
    end
    // shoot first seen high at edge n takes effect at edge n+2
    if (s && !m_shoot_prev) m_commit.push_back(n + 2);
    m_shoot_prev = s;
    if (m_commit.size() > 0 && m_commit[0] == n) begin
      void'(m_commit.pop_front());
      if (m_pending) begin
        m_active  = m_pidx;
        m_pending = 1'b0;
        e = '{n, 2'b10, m_active, 4'h0};
      end else begin
        e = '{n, 2'b01, m_active, 4'h0};
      end
      sq.push_back(e);
    end
    if (d) begin
      if (p) begin
        e = '{n, 2'b01, 12'h000, 4'h0};
        fq.push_back(e);
        m_in_frame = 1'b0;
      end else if (!m_in_frame) begin
        m_hi       = b;
        m_hi_edge  = n;
        m_in_frame = 1'b1;
      end else begin
        m_last_sin = {m_hi, b[7:4]};
        m_last_id  = b[3:0];
        e = '{n, 2'b10, m_last_sin, m_last_id};
        fq.push_back(e);
        m_in_frame = 1'b0;
        if (accepts(b[3:0])) begin
          m_pending = 1'b1;
          m_pidx    = m_last_sin;
        end
      end
    end
  endtask

  // ---------------- monitor ----------------
  logic [11:0] last_active = 12'h000;
  ev_t me;

  always @(negedge clk) begin
    if (!reset) begin
      last_active = 12'h000;
    end else begin
      if (frame_valid || frame_error) begin
        if (fq.size() == 0) begin
          chk("frame_unexpected", int'({frame_valid, frame_error}), 0);
        end else begin
          me = fq.pop_front();
          chk("frame_edge", int'(cyc), int'(me.at));
          chk("frame_kind", int'({frame_valid, frame_error}), int'(me.kind));
          if (me.kind == 2'b10) begin
            chk("sin_index", int'(sin_index), int'(me.idx));
            chk("uart_id", int'(uart_id), int'(me.id));
          end
        end
      end else if (fq.size() > 0 && fq[0].at <= cyc) begin
        chk("frame_missing", 0, int'(fq[0].kind));
        void'(fq.pop_front());
      end
      if (apply || missed_shoot) begin
        if (sq.size() == 0) begin
          chk("shoot_unexpected", int'({apply, missed_shoot}), 0);
        end else begin
          me = sq.pop_front();
          chk("shoot_edge", int'(cyc), int'(me.at));
          chk("shoot_kind", int'({apply, missed_shoot}), int'(me.kind));
          chk("active_index", int'(active_index), int'(me.idx));
        end
      end else if (sq.size() > 0 && sq[0].at <= cyc) begin
        chk("shoot_missing", 0, int'(sq[0].kind));
        void'(sq.pop_front());
      end
      if (!apply) chk("active_hold", int'(active_index), int'(last_active));
      last_active = active_index;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic d, input logic [7:0] b, input logic p, input logic s);
    rx_done = d; rx_byte = b; parity_error = p; shoot = s;
    @(posedge clk); #1;
    model_step(cyc, d, b, p, s);
    rx_done = 1'b0; parity_error = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [7:0] b);
    drive(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic pulse_shoot();
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b0, 1'b1);
    idle(3);
  endtask

  task automatic check_reset_outputs();
    chk("rst_sin_index", int'(sin_index), 0);
    chk("rst_uart_id", int'(uart_id), 0);
    chk("rst_frame_valid", int'(frame_valid), 0);
    chk("rst_frame_error", int'(frame_error), 0);
    chk("rst_active_index", int'(active_index), 0);
    chk("rst_apply", int'(apply), 0);
    chk("rst_missed_shoot", int'(missed_shoot), 0);
  endtask

  task automatic do_reset();
    chk("drained_frame_q", fq.size(), 0);
    chk("drained_shoot_q", sq.size(), 0);
    #2 reset = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    fq.delete(); sq.delete(); m_commit.delete();
    m_in_frame = 1'b0; m_pending = 1'b0; m_pidx = 12'h000; m_active = 12'h000;
    m_shoot_prev = 1'b0; m_last_sin = 12'h000; m_last_id = 4'h0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic s_lvl;
    int   s_left;
    logic d;
    logic p;
    logic [7:0] b;

    repeat (2) @(posedge clk);
    #1 check_reset_outputs();
    reset = 1'b1;

    // basic frame 0xAB / 0xC1 ten edges apart, then commit
    send(8'hAB); idle(9); send(8'hC1); idle(3); pulse_shoot();

    // timeout after 0x12, then 0x34 / 0x51
    send(8'h12); idle(T + 3); send(8'h34); idle(2); send(8'h51); idle(2); pulse_shoot();

    // parity error on byte 2, then a shoot with nothing pending
    send(8'h55); idle(3); drive(1'b1, 8'h66, 1'b1, 1'b0); idle(2); pulse_shoot();
    // parity error on byte 1
    drive(1'b1, 8'h99, 1'b1, 1'b0); idle(2);

    // id filter sequence 2, F, 1 and a lone id-2 frame
    send(8'h11); idle(2); send(8'h12); idle(2);
    send(8'h22); idle(2); send(8'h3F); idle(2);
    send(8'h33); idle(2); send(8'h41); idle(2); pulse_shoot();
    send(8'h5A); idle(2); send(8'h52); idle(2); pulse_shoot();

    // byte 2 lands on the commit edge: 0x100 pending, new 0x200
    send(8'h10); idle(2); send(8'h01); idle(2);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 8'h20, 1'b0, 1'b1);
    drive(1'b1, 8'h01, 1'b0, 1'b1);
    idle(3); pulse_shoot();

    // timeout boundary: byte 2 at exactly T edges completes, at T+1 it does not
    send(8'h6E); idle(T - 1); send(8'hD1); idle(2);
    send(8'h7E); idle(T); send(8'hE2); idle(1); send(8'hF3); idle(2); pulse_shoot();

    // reset between byte 1 and byte 2; orphan byte becomes a new byte 1
    send(8'h77); idle(2);
    do_reset();
    send(8'h88); idle(1); send(8'h9F); idle(3); pulse_shoot();

    // randomized traffic with legal shoot high/low times
    s_lvl  = 1'b0;
    s_left = 2;
    for (int i = 0; i < 3000; i++) begin
      if (s_left == 0) begin
        s_lvl  = ~s_lvl;
        s_left = int'($urandom_range(2, 12));
      end
      s_left--;
      d = ($urandom_range(0, 19) < 3);
      p = ($urandom_range(0, 9) == 0);
      b = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       b[3:0] = MID;
        1:       b[3:0] = 4'hF;
        2:       b[3:0] = 4'h2;
        default: b[3:0] = b[3:0];
      endcase
      drive(d, b, p, s_lvl);
    end

    idle(T + 5);
    chk("final_frame_q", fq.size(), 0);
    chk("final_shoot_q", sq.size(), 0);
    chk("final_sin_index", int'(sin_index), int'(m_last_sin));
    chk("final_uart_id", int'(uart_id), int'(m_last_id));
    chk("final_active_index", int'(active_index), int'(m_active));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
